// File: rtl/od_bus_pkg.sv
// Shared definitions for the open-drain bus arbiter: FSM state encoding,
// fault bit positions and counter sizing.
package od_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int FLT_CONTENTION = 0;
    localparam int FLT_SETTLE     = 1;
    localparam int FLT_W          = 2;

    // One spare bit above the longest count so saturation never aliases a valid value.
    function automatic int cnt_width(input int hold, input int settle_max);
        int longest;
        longest = (hold > settle_max) ? hold : settle_max;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/od_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, in cyclic order.
// Purely combinational; reusable for any requester count N >= 2.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the far end back toward the pointer so the closest request wins.
    always_comb begin : pick
        int j;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = IW'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/od_bus_arbiter.sv
// Round-robin owner of a pulled-up open-drain line group: drives the owner's latched
// pattern, then releases the bus and waits for the readback to float back to all ones.
module od_bus_arbiter
    import od_bus_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 6,
    parameter int HOLD       = 2,
    parameter int SETTLE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      y_rb,
    output logic                  busy,
    output logic [FLT_W-1:0]      fault
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = cnt_width(HOLD, SETTLE_MAX);

    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_MAX - 1);
    localparam logic [PW-1:0] LAST_REQ    = PW'(NREQ - 1);

    arb_state_e        state, state_nx;
    logic [WIDTH-1:0]  pat, pat_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [PW-1:0]     ptr, ptr_nx;
    logic [PW-1:0]     owner, owner_nx;
    logic [NREQ-1:0]   gnt_nx;
    logic [NREQ-1:0]   done_nx;
    logic [WIDTH-1:0]  a_nx;
    logic              busy_nx;
    logic [FLT_W-1:0]  fault_nx;

    logic [NREQ-1:0]   pick_onehot;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;

    rr_pick #(
        .N  (NREQ),
        .IW (PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Every output is a flop; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pat   <= '1;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            done  <= '0;
            a     <= '1;
            busy  <= 1'b0;
            fault <= '0;
        end else begin
            state <= state_nx;
            pat   <= pat_nx;
            cnt   <= cnt_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            a     <= a_nx;
            busy  <= busy_nx;
            fault <= fault_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pat_nx   = pat;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        owner_nx = owner;
        gnt_nx   = gnt;
        done_nx  = '0;
        a_nx     = '1;
        busy_nx  = busy;
        fault_nx = fault;

        case (state)
            IDLE: begin
                gnt_nx  = '0;
                busy_nx = 1'b0;
                if (pick_valid) begin
                    owner_nx = pick_idx;
                    pat_nx   = wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    a_nx     = wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    gnt_nx   = pick_onehot;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = DRIVE;
                end
            end

            DRIVE: begin
                a_nx = pat;
                // The first driven cycle is skipped: readback still shows the previous level.
                if ((cnt != '0) && (|(pat & ~y_rb))) begin
                    fault_nx[FLT_CONTENTION] = 1'b1;
                end
                if ((cnt >= HOLD_LAST) && !req[owner]) begin
                    gnt_nx   = '0;
                    cnt_nx   = '0;
                    a_nx     = '1;
                    state_nx = RELEASE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            RELEASE: begin
                gnt_nx = '0;
                if ((&y_rb) || (cnt == SETTLE_LAST)) begin
                    if (!(&y_rb)) begin
                        fault_nx[FLT_SETTLE] = 1'b1;
                    end
                    done_nx[owner] = 1'b1;
                    ptr_nx         = (owner == LAST_REQ) ? '0 : owner + PW'(1);
                    cnt_nx         = '0;
                    busy_nx        = 1'b0;
                    state_nx       = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            default: begin
                gnt_nx   = '0;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_od_bus_arbiter.sv
// Bench for od_bus_arbiter: wired-AND bus with pull-up, directed scenarios plus random
// traffic, all compared every cycle against a transaction-level reference model.
module tb_od_bus_arbiter;

    localparam int NREQ       = 4;
    localparam int WIDTH      = 6;
    localparam int HOLD       = 2;
    localparam int SETTLE_MAX = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      y_rb;
    logic                  busy;
    logic [1:0]            fault;
    logic [WIDTH-1:0]      ext_low = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 = bus free, 1 = owner driving, 2 = waiting for float-up.
    int               m_phase = 0;
    int               m_ptr = 0;
    int               m_owner = 0;
    int               m_held = 0;
    int               m_wait = 0;
    logic [WIDTH-1:0] m_pat = '1;
    logic [WIDTH-1:0] exp_a = '1;
    logic [NREQ-1:0]  exp_gnt = '0;
    logic [NREQ-1:0]  exp_done = '0;
    logic             exp_busy = 1'b0;
    logic [1:0]       exp_fault = '0;

    always #5 clk = ~clk;

    // Open-drain buffers on a pulled-up bus: any low driver wins.
    assign y_rb = a & ~ext_low;

    od_bus_arbiter #(
        .NREQ       (NREQ),
        .WIDTH      (WIDTH),
        .HOLD       (HOLD),
        .SETTLE_MAX (SETTLE_MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .done  (done),
        .a     (a),
        .y_rb  (y_rb),
        .busy  (busy),
        .fault (fault)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [WIDTH-1:0] ext);
        req     = r;
        ext_low = ext;
    endtask

    task automatic waitDone(input string name, input logic [NREQ-1:0] want, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (done == '0 && cycles < 40);
        checkOutput(name, 32'(done), 32'(want));
    endtask

    function automatic int gnt_index(input logic [NREQ-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_ptr     = 0;
        exp_a     = '1;
        exp_gnt   = '0;
        exp_done  = '0;
        exp_busy  = 1'b0;
        exp_fault = '0;
    endtask

    // Advance the model across the coming rising edge using the inputs it will see there.
    task automatic model_step();
        logic [WIDTH-1:0] y_model;
        int w;
        y_model  = exp_a & ~ext_low;
        exp_done = '0;
        if (m_phase == 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                m_owner    = w;
                m_pat      = wdata[w*WIDTH +: WIDTH];
                m_held     = 0;
                m_phase    = 1;
                exp_gnt    = '0;
                exp_gnt[w] = 1'b1;
                exp_a      = m_pat;
                exp_busy   = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (m_held >= 1 && (m_pat & ~y_model) != '0) exp_fault[0] = 1'b1;
            if (m_held >= HOLD - 1 && !req[m_owner]) begin
                m_phase = 2;
                m_wait  = 0;
                exp_gnt = '0;
                exp_a   = '1;
            end else begin
                m_held++;
            end
        end else begin
            if (y_model == '1 || m_wait == SETTLE_MAX - 1) begin
                if (y_model != '1) exp_fault[1] = 1'b1;
                exp_done[m_owner] = 1'b1;
                m_ptr    = (m_owner + 1) % NREQ;
                m_phase  = 0;
                exp_busy = 1'b0;
            end else begin
                m_wait++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) model_reset();
        checkOutput("a", 32'(a), 32'(exp_a));
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("done", 32'(done), 32'(exp_done));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("fault", 32'(fault), 32'(exp_fault));
        if (!rst) model_step();
    end

    initial begin
        int cyc;
        int n_gr;
        int order [5];
        int gr_cyc [5];
        int want_order [5];
        logic [NREQ-1:0] prev_g;

        want_order = '{0, 1, 2, 3, 0};
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_a", 32'(a), 32'h3F);
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_fault", 32'(fault), 32'h0);

        // Single transfer from requester 2
        wdata[2*WIDTH +: WIDTH] = 6'b101010;
        applyStimulus(4'b0100, '0);
        tick();
        checkOutput("t1_gnt", 32'(gnt), 32'h4);
        checkOutput("t1_a", 32'(a), 32'h2A);
        tick();
        tick();
        checkOutput("t1_gnt_3rd", 32'(gnt), 32'h4);
        applyStimulus(4'b0000, '0);
        tick();
        checkOutput("t1_gnt_drop", 32'(gnt), 32'h0);
        checkOutput("t1_a_release", 32'(a), 32'h3F);
        tick();
        checkOutput("t1_done", 32'(done), 32'h4);
        checkOutput("t1_busy", 32'(busy), 32'h0);
        checkOutput("t1_fault", 32'(fault), 32'h0);

        // Round robin from a fresh pointer, each owner letting go as early as allowed
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(4'b1111, '0);
        n_gr = 0;
        prev_g = '0;
        for (cyc = 0; cyc < 200 && n_gr < 5; cyc++) begin
            tick();
            if (gnt != '0 && prev_g == '0) begin
                order[n_gr]  = gnt_index(gnt);
                gr_cyc[n_gr] = cyc;
                n_gr++;
            end
            prev_g = gnt;
            req = 4'b1111 & ~gnt;
        end
        checkOutput("t2_grant_count", 32'(n_gr), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < n_gr) checkOutput("t2_order", 32'(order[i]), 32'(want_order[i]));
        end
        if (n_gr >= 2) checkOutput("t2_period", 32'(gr_cyc[1] - gr_cyc[0]), 32'(HOLD + 2));
        applyStimulus(4'b0000, '0);
        waitDone("t2_done", 4'b0001, cyc);

        // Contention on line 0 against an all-released pattern
        wdata[1*WIDTH +: WIDTH] = 6'b111111;
        applyStimulus(4'b0010, 6'b000001);
        tick();
        checkOutput("t3_gnt", 32'(gnt), 32'h2);
        tick();
        checkOutput("t3_no_fault_cnt0", 32'(fault), 32'h0);
        tick();
        checkOutput("t3_fault", 32'(fault), 32'h1);
        applyStimulus(4'b0000, '0);
        waitDone("t3_done", 4'b0010, cyc);

        // Line 5 stuck low through the release window
        wdata[2*WIDTH +: WIDTH] = 6'b010101;
        applyStimulus(4'b0100, 6'b100000);
        tick();
        checkOutput("t4_gnt", 32'(gnt), 32'h4);
        tick();
        applyStimulus(4'b0000, 6'b100000);
        tick();
        checkOutput("t4_released", 32'(a), 32'h3F);
        waitDone("t4_done", 4'b0100, cyc);
        checkOutput("t4_settle_cycles", 32'(cyc), 32'(SETTLE_MAX));
        checkOutput("t4_fault", 32'(fault), 32'h3);
        applyStimulus(4'b1000, '0);
        tick();
        checkOutput("t4_next_grant", 32'(gnt), 32'h8);
        applyStimulus(4'b0000, '0);
        waitDone("t4_next_done", 4'b1000, cyc);

        // Reset between edges while requester 0 drives zeros
        wdata[0 +: WIDTH] = 6'b000000;
        applyStimulus(4'b0001, '0);
        tick();
        checkOutput("t5_gnt", 32'(gnt), 32'h1);
        checkOutput("t5_a", 32'(a), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_async_a", 32'(a), 32'h3F);
        checkOutput("t5_async_gnt", 32'(gnt), 32'h0);
        checkOutput("t5_async_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b1000, '0);
        tick();
        checkOutput("t5_grant_after_rst", 32'(gnt), 32'h8);
        applyStimulus(4'b0000, '0);
        waitDone("t5_done", 4'b1000, cyc);

        // Requester 1 pulses between edges; only the steady requester 3 is served
        applyStimulus(4'b1000, '0);
        #1;
        req = 4'b1010;
        #2;
        req = 4'b1000;
        tick();
        checkOutput("t6_gnt", 32'(gnt), 32'h8);
        applyStimulus(4'b0000, '0);
        waitDone("t6_done", 4'b1000, cyc);

        // Random traffic, occasional external pull-downs and resets
        for (int c = 0; c < 600; c++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
            wdata   = {$urandom, $urandom};
            ext_low = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : '0;
        end
        rst = 1'b0;
        applyStimulus(4'b0000, '0);
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
